// File: rtl/hcube_router.sv
// hcube_router: one clocked node of a 2^DIM-node hypercube network.
// DIM neighbour ports plus one local inject/eject port (index DIM), each input
// buffered by its own FIFO, e-cube routing (lowest differing address bit first),
// a round-robin arbiter and a one-entry output register per output.
// Optional feature: define HCUBE_STATS_EN to add saturating 16-bit
// per-output forwarded-packet counters on port stat_fwd_cnt.
module hcube_router #(
  parameter int DIM = 4,
  parameter int PAYLOAD_W = 4,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DIM-1:0] MY_ADDR = '0,
  localparam int P = DIM + 1,
  localparam int PKT_W = DIM + PAYLOAD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [P-1:0]       in_valid,
  input  logic [P*PKT_W-1:0] in_data,
  output logic [P-1:0]       in_ready,
  output logic [P-1:0]       out_valid,
  output logic [P*PKT_W-1:0] out_data,
  input  logic [P-1:0]       out_ready
`ifdef HCUBE_STATS_EN
  ,
  output logic [P*16-1:0]    stat_fwd_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(P);

  logic [PKT_W-1:0]           mem_q [P][FIFO_DEPTH];
  logic [PKT_W-1:0]           mem_d [P][FIFO_DEPTH];
  logic [P-1:0][AW:0]         wptr_q, wptr_d;
  logic [P-1:0][AW:0]         rptr_q, rptr_d;
  logic [P-1:0]               in_ready_q, in_ready_d;
  logic [P-1:0]               out_valid_q, out_valid_d;
  logic [P-1:0][PKT_W-1:0]    out_data_q, out_data_d;
  logic [P-1:0][RW-1:0]       rr_ptr_q, rr_ptr_d;

  logic [P-1:0][PKT_W-1:0]    head;
  logic [P-1:0]               fifo_empty;
  logic [P-1:0][RW-1:0]       route;
  logic [P-1:0]               push;
  logic [P-1:0]               pop;

  // FIFO head, emptiness and e-cube output choice for each input's head packet
  always_comb begin
    for (int i = 0; i < P; i++) begin
      head[i]       = mem_q[i][rptr_q[i][AW-1:0]];
      fifo_empty[i] = (wptr_q[i] == rptr_q[i]);
      route[i]      = RW'(DIM);
      for (int k = DIM - 1; k >= 0; k--) begin
        if (head[i][PAYLOAD_W + k] ^ MY_ADDR[k]) begin
          route[i] = RW'(k);
        end
      end
    end
  end

  // Per-output round-robin arbitration and output register load / handshake
  always_comb begin
    int              sum;
    logic            found;
    logic [RW-1:0]   idx;
    logic [RW-1:0]   sel;
    pop         = '0;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    sum         = 0;
    found       = 1'b0;
    idx         = '0;
    sel         = '0;
    for (int o = 0; o < P; o++) begin
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < P; k++) begin
        sum = int'(rr_ptr_q[o]) + k;
        if (sum >= P) begin
          sum = sum - P;
        end
        idx = RW'(sum);
        if (!found && !fifo_empty[idx] && (route[idx] == RW'(o))) begin
          found = 1'b1;
          sel   = idx;
        end
      end
      if (found && (!out_valid_q[o] || out_ready[o])) begin
        pop[sel]       = 1'b1;
        out_valid_d[o] = 1'b1;
        out_data_d[o]  = head[sel];
        rr_ptr_d[o]    = (int'(sel) == P - 1) ? '0 : sel + 1'b1;
      end
    end
  end

  // FIFO writes, pointer advance and the registered !full ready indication
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < P; i++) begin
      push[i]   = in_valid[i] && in_ready_q[i];
      wptr_d[i] = wptr_q[i] + {{AW{1'b0}}, push[i]};
      rptr_d[i] = rptr_q[i] + {{AW{1'b0}}, pop[i]};
      if (push[i]) begin
        mem_d[i][wptr_q[i][AW-1:0]] = in_data[i*PKT_W +: PKT_W];
      end
      in_ready_d[i] = !((wptr_d[i][AW] != rptr_d[i][AW]) &&
                        (wptr_d[i][AW-1:0] == rptr_d[i][AW-1:0]));
    end
  end

  // Control state: reset discards every buffered and in-flight packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      in_ready_q  <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef HCUBE_STATS_EN
  logic [P-1:0][15:0] stat_cnt_q, stat_cnt_d;

  // Saturating count of completed output handshakes
  always_comb begin
    stat_cnt_d = stat_cnt_q;
    for (int o = 0; o < P; o++) begin
      if (out_valid_q[o] && out_ready[o] && (stat_cnt_q[o] != 16'hFFFF)) begin
        stat_cnt_d[o] = stat_cnt_q[o] + 16'd1;
      end
    end
  end

  // Counter register, cleared with the rest of the node
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_q <= '0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_fwd_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_hcube_router.sv
// tb_hcube_router: directed self-checking bench for hcube_router
// (DIM=4, PAYLOAD_W=4, FIFO_DEPTH=4, MY_ADDR=0). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_hcube_router;

  localparam int P = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [P-1:0]   in_valid;
  logic [P*8-1:0] in_data;
  logic [P-1:0]   in_ready;
  logic [P-1:0]   out_valid;
  logic [P*8-1:0] out_data;
  logic [P-1:0]   out_ready;
`ifdef HCUBE_STATS_EN
  logic [P*16-1:0] stat_fwd_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] basic_pkt [4] = '{8'h11, 8'h73, 8'h85, 8'h4A};
  int         basic_port [4] = '{0, 0, 3, 2};

  hcube_router dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef HCUBE_STATS_EN
    ,
    .stat_fwd_cnt (stat_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    in_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 5'b0) begin
      err_cnt++; $display("[TB] FAIL reset_out_valid: got %b want %b", out_valid, 5'b0);
    end
    vec_cnt++;
    if (out_data !== 40'h0) begin
      err_cnt++; $display("[TB] FAIL reset_out_data: got %h want %h", out_data, 40'h0);
    end
    vec_cnt++;
    if (in_ready !== 5'b0) begin
      err_cnt++; $display("[TB] FAIL reset_in_ready: got %b want %b", in_ready, 5'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (in_ready !== 5'b11111) begin
      err_cnt++; $display("[TB] FAIL reset_release_ready: got %b want %b", in_ready, 5'b11111);
    end
  endtask

  task automatic test_basic();
    for (int j = 0; j < 4; j++) begin
      in_valid[4] = 1'b1;
      in_data[32 +: 8] = basic_pkt[j];
      @(negedge clk);
      in_valid[4] = 1'b0;
      vec_cnt++;
      if (out_valid !== 5'b0) begin
        err_cnt++; $display("[TB] FAIL basic_latency[%0d]: got %b want %b", j, out_valid, 5'b0);
      end
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== (5'b1 << basic_port[j]) ||
          out_data[basic_port[j]*8 +: 8] !== basic_pkt[j]) begin
        err_cnt++;
        $display("[TB] FAIL basic_route[%0d]: got valid %b data %h want valid %b data %h",
                 j, out_valid, out_data[basic_port[j]*8 +: 8], 5'b1 << basic_port[j], basic_pkt[j]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_eject();
    in_valid[1] = 1'b1;
    in_data[8 +: 8] = 8'h0C;
    @(negedge clk);
    in_valid[1] = 1'b0;
    vec_cnt++;
    if (out_valid !== 5'b0) begin
      err_cnt++; $display("[TB] FAIL eject_early: got %b want %b", out_valid, 5'b0);
    end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 5'b10000 || out_data[32 +: 8] !== 8'h0C) begin
      err_cnt++;
      $display("[TB] FAIL eject_out: got valid %b data %h want valid %b data %h",
               out_valid, out_data[32 +: 8], 5'b10000, 8'h0C);
    end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 5'b0) begin
      err_cnt++; $display("[TB] FAIL eject_done: got %b want %b", out_valid, 5'b0);
    end
  endtask

  task automatic test_contention();
    in_valid = 5'b10110;
    in_data[8 +: 8]  = 8'h11;
    in_data[16 +: 8] = 8'h12;
    in_data[32 +: 8] = 8'h13;
    @(negedge clk);
    in_valid = '0;
    vec_cnt++;
    if (out_valid !== 5'b0) begin
      err_cnt++; $display("[TB] FAIL contention_early: got %b want %b", out_valid, 5'b0);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 5'b00001 || out_data[7:0] !== (8'h11 + 8'(j))) begin
        err_cnt++;
        $display("[TB] FAIL contention_order[%0d]: got valid %b data %h want valid %b data %h",
                 j, out_valid, out_data[7:0], 5'b00001, 8'h11 + 8'(j));
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 5'b0) begin
      err_cnt++; $display("[TB] FAIL contention_drained: got %b want %b", out_valid, 5'b0);
    end
    vec_cnt++;
    if (dut.rr_ptr_q[0] !== 3'd0) begin
      err_cnt++; $display("[TB] FAIL contention_rr_ptr: got %0d want %0d", dut.rr_ptr_q[0], 0);
    end
  endtask

  task automatic test_backpressure();
    logic accept_next;
    do_reset();
    out_ready = 5'b11110;
    for (int j = 0; j < 6; j++) begin
      in_valid[1] = 1'b1;
      in_data[8 +: 8] = 8'h10 + 8'(j);
      vec_cnt++;
      if (in_ready[1] !== (j < 5)) begin
        err_cnt++; $display("[TB] FAIL bp_ready[%0d]: got %b want %b", j, in_ready[1], (j < 5));
      end
      if (j < 5) @(negedge clk);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      vec_cnt++;
      if (in_ready[1] !== 1'b0 || out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h10) begin
        err_cnt++;
        $display("[TB] FAIL bp_hold[%0d]: got ready %b valid %b data %h want ready 0 valid 1 data 10",
                 j, in_ready[1], out_valid[0], out_data[7:0]);
      end
    end
    out_ready = 5'b11111;
    accept_next = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (accept_next) in_valid[1] = 1'b0;
      accept_next = in_valid[1] && in_ready[1];
      vec_cnt++;
      if (out_valid[0] !== 1'b1 || out_data[7:0] !== (8'h10 + 8'(j))) begin
        err_cnt++;
        $display("[TB] FAIL bp_drain[%0d]: got valid %b data %h want valid 1 data %h",
                 j, out_valid[0], out_data[7:0], 8'h10 + 8'(j));
      end
      @(negedge clk);
    end
    if (accept_next) in_valid[1] = 1'b0;
    vec_cnt++;
    if (out_valid !== 5'b0) begin
      err_cnt++; $display("[TB] FAIL bp_empty: got %b want %b", out_valid, 5'b0);
    end
  endtask

`ifdef HCUBE_STATS_EN
  task automatic test_stats();
    out_ready = '1;
    in_valid  = '0;
    @(negedge clk);
    vec_cnt++;
    if (stat_fwd_cnt[15:0] !== 16'd6) begin
      err_cnt++; $display("[TB] FAIL stats_count: got %0d want %0d", stat_fwd_cnt[15:0], 6);
    end
    force dut.stat_cnt_q = {P{16'hFFFD}};
    @(negedge clk);
    release dut.stat_cnt_q;
    for (int j = 0; j < 3; j++) begin
      in_valid[4] = 1'b1;
      in_data[32 +: 8] = 8'h11 + 8'(j);
      @(negedge clk);
    end
    in_valid = '0;
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (stat_fwd_cnt[15:0] !== 16'hFFFF) begin
      err_cnt++; $display("[TB] FAIL stats_saturate: got %h want %h", stat_fwd_cnt[15:0], 16'hFFFF);
    end
  endtask
`endif

  task automatic test_reset_midflight();
    out_ready = 5'b11110;
    for (int j = 0; j < 3; j++) begin
      in_valid[4] = 1'b1;
      in_data[32 +: 8] = 8'h1A + 8'(j);
      @(negedge clk);
    end
    in_valid = '0;
    @(negedge clk);
    vec_cnt++;
    if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h1A) begin
      err_cnt++;
      $display("[TB] FAIL midrst_loaded: got valid %b data %h want valid 1 data 1a",
               out_valid[0], out_data[7:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 5'b0 || in_ready !== 5'b0 || out_data !== 40'h0) begin
      err_cnt++;
      $display("[TB] FAIL midrst_async: got valid %b ready %b data %h want all zero",
               out_valid, in_ready, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = '1;
    vec_cnt++;
    if (in_ready !== 5'b0) begin
      err_cnt++; $display("[TB] FAIL midrst_ready_early: got %b want %b", in_ready, 5'b0);
    end
    @(negedge clk);
    vec_cnt++;
    if (in_ready !== 5'b11111) begin
      err_cnt++; $display("[TB] FAIL midrst_ready: got %b want %b", in_ready, 5'b11111);
    end
    for (int j = 0; j < 4; j++) begin
      vec_cnt++;
      if (out_valid !== 5'b0) begin
        err_cnt++; $display("[TB] FAIL midrst_stale[%0d]: got %b want %b", j, out_valid, 5'b0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_eject();
    test_contention();
    test_backpressure();
`ifdef HCUBE_STATS_EN
    test_stats();
`endif
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
